ds_hazard_ctrl: RTL and testbench

Register-hazard controller for the decode stage of the 5-stage LoongArch pipeline. Keeps a shadow pipeline of destination tags for the EX, MEM and WB stages, driven by the existing stage handshakes. From those tags it produces, for both register-file read ports, the decode-stage ready signal (interlock) and forwarding selects. It replaces the ad-hoc crush logic inside the decode stage and also counts stall cycles.

---
 rtl/ds_hazard_ctrl_pkg.sv | 30 +++
 rtl/hz_tag_pipe.sv | 33 +++
 rtl/ds_hazard_ctrl.sv | 91 +++++++++
 tb/tb_ds_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_hazard_ctrl_pkg.sv
// Shared types for the decode-stage hazard controller: GPR address width,
// forwarding-select codes and the E/M/W destination-tag entry.
package ds_hazard_ctrl_pkg;

  localparam int unsigned GPR_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic              v;
    logic              we;
    logic [GPR_AW-1:0] dest;
    logic              ld;
  } hz_tag_t;

  typedef struct packed {
    logic     hazard;
    fwd_sel_e sel;
  } port_res_t;

  function automatic logic tag_hit(hz_tag_t t, logic rd_en, logic [GPR_AW-1:0] raddr);
    return rd_en && (raddr != '0) && t.v && t.we && (t.dest == raddr);
  endfunction

endpackage

// File: rtl/hz_tag_pipe.sv
// Three-entry E/M/W destination-tag shadow pipeline, advanced by the stage
// allow-in/valid handshakes; flush and reset clear every entry.
module hz_tag_pipe
  import ds_hazard_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  input  logic    ds_fire,
  input  hz_tag_t ds_tag,
  input  logic    es_allow_in,
  input  logic    ms_allow_in,
  input  logic    ws_allow_in,
  input  logic    es_to_ms_valid,
  input  logic    ms_to_ws_valid,
  output hz_tag_t e_tag,
  output hz_tag_t m_tag,
  output hz_tag_t w_tag
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      e_tag <= '0;
      m_tag <= '0;
      w_tag <= '0;
    end else begin
      if (es_allow_in) e_tag <= ds_fire ? ds_tag : '0;
      if (ms_allow_in) m_tag <= es_to_ms_valid ? e_tag : '0;
      if (ws_allow_in) w_tag <= ms_to_ws_valid ? m_tag : '0;
    end
  end

endmodule

// File: rtl/ds_hazard_ctrl.sv
// Decode-stage register-hazard controller: interlock, forwarding selects and
// a saturating stall counter. Define FORWARD_EN for forwarding; default is pure interlock.
module ds_hazard_ctrl
  import ds_hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ds_valid,
  input  logic              rd_en1,
  input  logic              rd_en2,
  input  logic [GPR_AW-1:0] raddr1,
  input  logic [GPR_AW-1:0] raddr2,
  input  logic              ds_we,
  input  logic [GPR_AW-1:0] ds_dest,
  input  logic              ds_is_load,
  input  logic              es_allow_in,
  input  logic              ms_allow_in,
  input  logic              ws_allow_in,
  input  logic              es_to_ms_valid,
  input  logic              ms_to_ws_valid,
  input  logic              flush,
  output logic              ds_ready_go,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [31:0]       stall_cnt
);

  hz_tag_t   e_tag, m_tag, w_tag, ds_tag;
  port_res_t res1, res2;
  logic      ds_fire;

  // Youngest producer wins: E is checked before M before W.
  function automatic port_res_t resolve(hz_tag_t e, hz_tag_t m, hz_tag_t w,
                                        logic rd_en, logic [GPR_AW-1:0] raddr);
    port_res_t r;
    logic      hit_e, hit_m, hit_w;
    hit_e    = tag_hit(e, rd_en, raddr);
    hit_m    = tag_hit(m, rd_en, raddr);
    hit_w    = tag_hit(w, rd_en, raddr);
    r.hazard = 1'b0;
    r.sel    = FWD_RF;
`ifdef FORWARD_EN
    if (hit_e) begin
      r.sel    = FWD_EX;
      r.hazard = e.ld;
    end else if (hit_m) begin
      r.sel = FWD_MEM;
    end else if (hit_w) begin
      r.sel = FWD_WB;
    end
`else
    r.hazard = hit_e | hit_m | hit_w;
`endif
    return r;
  endfunction

  always_comb begin
    ds_tag      = '{v: 1'b1, we: ds_we, dest: ds_dest, ld: ds_is_load};
    res1        = resolve(e_tag, m_tag, w_tag, rd_en1, raddr1);
    res2        = resolve(e_tag, m_tag, w_tag, rd_en2, raddr2);
    ds_ready_go = ~(res1.hazard | res2.hazard);
    fwd_sel1    = res1.sel;
    fwd_sel2    = res2.sel;
    ds_fire     = ds_valid & ds_ready_go & es_allow_in;
  end

  hz_tag_pipe u_tag_pipe (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .ds_fire        (ds_fire),
    .ds_tag         (ds_tag),
    .es_allow_in    (es_allow_in),
    .ms_allow_in    (ms_allow_in),
    .ws_allow_in    (ws_allow_in),
    .es_to_ms_valid (es_to_ms_valid),
    .ms_to_ws_valid (ms_to_ws_valid),
    .e_tag          (e_tag),
    .m_tag          (m_tag),
    .w_tag          (w_tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (ds_valid && !ds_ready_go && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ds_hazard_ctrl.sv
// Scoreboard bench for ds_hazard_ctrl: an in-flight instruction model predicts
// ready/forwarding/stall count each cycle; a negedge monitor compares.
module tb_ds_hazard_ctrl;
  import ds_hazard_ctrl_pkg::*;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, ds_valid, rd_en1, rd_en2, ds_we, ds_is_load, flush;
  logic        es_allow_in, ms_allow_in, ws_allow_in, es_to_ms_valid, ms_to_ws_valid;
  logic [4:0]  raddr1, raddr2, ds_dest;
  logic        ds_ready_go;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  ds_hazard_ctrl dut (
    .clk(clk), .reset(reset), .ds_valid(ds_valid),
    .rd_en1(rd_en1), .rd_en2(rd_en2), .raddr1(raddr1), .raddr2(raddr2),
    .ds_we(ds_we), .ds_dest(ds_dest), .ds_is_load(ds_is_load),
    .es_allow_in(es_allow_in), .ms_allow_in(ms_allow_in), .ws_allow_in(ws_allow_in),
    .es_to_ms_valid(es_to_ms_valid), .ms_to_ws_valid(ms_to_ws_valid), .flush(flush),
    .ds_ready_go(ds_ready_go), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_cnt(stall_cnt)
  );

  // Reference model: the instruction occupying each downstream stage (0=EX, 1=MEM, 2=WB).
  typedef struct { bit live; bit we; int dest; bit ld; } inst_t;
  typedef struct { bit rdy; logic [1:0] s1; logic [1:0] s2; logic [31:0] cnt; } exp_t;

  inst_t       stg [3];
  logic [31:0] m_cnt = '0;
  exp_t        sb [$];
  bit          chk_en = 1'b0;
  bit          last_rdy;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Stage index of the youngest in-flight writer of raddr, or -1.
  function automatic int youngest(bit rd_en, int raddr);
    if (!rd_en || raddr == 0) return -1;
    for (int s = 0; s < 3; s++)
      if (stg[s].live && stg[s].we && stg[s].dest == raddr) return s;
    return -1;
  endfunction

  function automatic bit port_hazard(int s);
    if (FWD) return (s == 0) && stg[0].ld;
    return s >= 0;
  endfunction

  function automatic logic [1:0] port_sel(int s);
    if (!FWD || s < 0) return 2'b00;
    return 2'(s + 1);
  endfunction

  task automatic advance(input bit fire);
    inst_t none, n0, n1, n2;
    none = '{live: 1'b0, we: 1'b0, dest: 0, ld: 1'b0};
    if (reset || flush) begin
      for (int s = 0; s < 3; s++) stg[s] = none;
    end else begin
      n0 = es_allow_in ? (fire ? '{live: 1'b1, we: ds_we, dest: int'(ds_dest), ld: ds_is_load} : none) : stg[0];
      n1 = ms_allow_in ? (es_to_ms_valid ? stg[0] : none) : stg[1];
      n2 = ws_allow_in ? (ms_to_ws_valid ? stg[1] : none) : stg[2];
      stg[0] = n0; stg[1] = n1; stg[2] = n2;
    end
  endtask

  // One clock: predict outputs for the inputs now applied, then step the model at the edge.
  task automatic cycle();
    exp_t x;
    int   s1, s2;
    s1    = youngest(rd_en1, int'(raddr1));
    s2    = youngest(rd_en2, int'(raddr2));
    x.rdy = !(port_hazard(s1) || port_hazard(s2));
    x.s1  = port_sel(s1);
    x.s2  = port_sel(s2);
    x.cnt = m_cnt;
    if (chk_en) sb.push_back(x);
    last_rdy = x.rdy;
    @(posedge clk);
    if (reset) m_cnt = '0;
    else if (ds_valid && !x.rdy && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    advance(ds_valid && x.rdy && es_allow_in);
    #1;
  endtask

  task automatic set_ds(input bit v, input bit e1, input int a1, input bit e2, input int a2,
                        input bit we, input int dest, input bit ld);
    ds_valid = v; rd_en1 = e1; raddr1 = 5'(a1); rd_en2 = e2; raddr2 = 5'(a2);
    ds_we = we; ds_dest = 5'(dest); ds_is_load = ld;
  endtask

  task automatic idle();
    set_ds(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Clock until the held decode instruction issues, bounded.
  task automatic drain(input string name);
    bit issued = 1'b0;
    for (int i = 0; i < 8 && !issued; i++) begin
      cycle();
      issued = last_rdy;
    end
    chk({name, "_issue"}, {31'd0, issued}, 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("ready", {31'd0, ds_ready_go}, {31'd0, x.rdy});
      chk("fwd_sel1", {30'd0, fwd_sel1}, {30'd0, x.s1});
      chk("fwd_sel2", {30'd0, fwd_sel2}, {30'd0, x.s2});
      chk("stall_cnt", stall_cnt, x.cnt);
    end
  end

  initial begin
    for (int s = 0; s < 3; s++) stg[s] = '{live: 1'b0, we: 1'b0, dest: 0, ld: 1'b0};
    es_allow_in = 1; ms_allow_in = 1; ws_allow_in = 1;
    es_to_ms_valid = 1; ms_to_ws_valid = 1; flush = 0;
    reset = 1; idle();
    cycle();
    chk_en = 1'b1;
    cycle();
    reset = 0;

    // Reset state
    #2;
    chk("rst_ready", {31'd0, ds_ready_go}, 32'd1);
    chk("rst_sel1", {30'd0, fwd_sel1}, 32'd0);
    chk("rst_sel2", {30'd0, fwd_sel2}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    cycle();

    // add r5 ; add r6 <- r5
    set_ds(1, 0, 0, 0, 0, 1, 5, 0); cycle();
    set_ds(1, 1, 5, 1, 3, 1, 6, 0);
    #2;
    chk("alu_dep_sel1", {30'd0, fwd_sel1}, FWD ? 32'd1 : 32'd0);
    chk("alu_dep_ready", {31'd0, ds_ready_go}, FWD ? 32'd1 : 32'd0);
    drain("alu_dep");
    idle(); #2;
    chk("alu_dep_cnt", stall_cnt, FWD ? 32'd0 : 32'd3);

    // ld.w r4 ; use r4 on port 2
    set_ds(1, 0, 0, 0, 0, 1, 4, 1); cycle();
    set_ds(1, 0, 0, 1, 4, 1, 8, 0);
    #2;
    chk("ld_use_stall", {31'd0, ds_ready_go}, 32'd0);
    cycle(); #2;
    chk("ld_use_after", {31'd0, ds_ready_go}, FWD ? 32'd1 : 32'd0);
    if (FWD) chk("ld_use_sel2", {30'd0, fwd_sel2}, 32'd2);
    drain("ld_use");

    // r7 producers in WB and EX
    set_ds(1, 0, 0, 0, 0, 1, 7, 0); cycle();
    idle(); cycle();
    set_ds(1, 0, 0, 0, 0, 1, 7, 0); cycle();
    set_ds(1, 1, 7, 0, 0, 0, 0, 0);
    #2;
    chk("youngest_sel1", {30'd0, fwd_sel1}, FWD ? 32'd1 : 32'd0);
    drain("youngest");

    // r0 read while EX writes r0; unused port matching EX dest
    set_ds(1, 0, 0, 0, 0, 1, 0, 0); cycle();
    set_ds(1, 1, 0, 0, 0, 1, 9, 0);
    #2;
    chk("r0_ready", {31'd0, ds_ready_go}, 32'd1);
    chk("r0_sel1", {30'd0, fwd_sel1}, 32'd0);
    cycle();
    set_ds(1, 1, 0, 0, 9, 0, 0, 0);
    #2;
    chk("rden_ready", {31'd0, ds_ready_go}, 32'd1);
    chk("rden_sel2", {30'd0, fwd_sel2}, 32'd0);
    cycle();

    // Flush mid load-use stall
    set_ds(1, 0, 0, 0, 0, 1, 4, 1); cycle();
    set_ds(1, 1, 4, 0, 0, 0, 0, 0);
    #2;
    chk("flush_pre", {31'd0, ds_ready_go}, 32'd0);
    flush = 1; cycle(); flush = 0;
    #2;
    chk("flush_ready", {31'd0, ds_ready_go}, 32'd1);
    chk("flush_sel1", {30'd0, fwd_sel1}, 32'd0);
    cycle();

    // Saturation: hold the load in EX so the stall persists
    set_ds(1, 0, 0, 0, 0, 1, 4, 1); cycle();
    set_ds(1, 1, 4, 0, 0, 0, 0, 0);
    es_allow_in = 0;
    force dut.stall_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    cycle();
    release dut.stall_cnt;
    #2;
    chk("sat_hold1", stall_cnt, 32'hFFFF_FFFF);
    cycle(); #2;
    chk("sat_hold2", stall_cnt, 32'hFFFF_FFFF);
    es_allow_in = 1;
    drain("sat");

    // Randomized traffic
    idle(); reset = 1; cycle(); reset = 0;
    for (int i = 0; i < 400; i++) begin
      ds_valid       = ($urandom_range(0, 3) != 0);
      rd_en1         = 1'($urandom);
      rd_en2         = 1'($urandom);
      raddr1         = 5'($urandom_range(0, 7));
      raddr2         = 5'($urandom_range(0, 7));
      ds_we          = ($urandom_range(0, 3) != 0);
      ds_dest        = 5'($urandom_range(0, 7));
      ds_is_load     = ($urandom_range(0, 2) == 0);
      es_allow_in    = ($urandom_range(0, 4) != 0);
      ms_allow_in    = ($urandom_range(0, 4) != 0);
      ws_allow_in    = ($urandom_range(0, 4) != 0);
      es_to_ms_valid = ($urandom_range(0, 5) != 0);
      ms_to_ws_valid = ($urandom_range(0, 5) != 0);
      flush          = ($urandom_range(0, 31) == 0);
      reset          = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 0; flush = 0; idle();
    es_allow_in = 1; ms_allow_in = 1; ws_allow_in = 1;
    es_to_ms_valid = 1; ms_to_ws_valid = 1;
    chk_en = 1'b0;
    cycle(); cycle();
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
